// File: rtl/fifo_pkg.sv
// Shared types for the parametrised FIFO: status encoding and its decode helper.
package fifo_pkg;

    typedef enum logic [1:0] {
        COND_EMPTY = 2'b00,
        COND_PART  = 2'b10,
        COND_FULL  = 2'b11
    } cond_t;

    function automatic cond_t cond_decode(input logic is_empty, input logic is_full);
        if (is_empty)
            return COND_EMPTY;
        else if (is_full)
            return COND_FULL;
        else
            return COND_PART;
    endfunction

endpackage

// File: rtl/fifo_param_if.sv
// FIFO data/status bundle; master drives requests, slave is the FIFO.
// FIFO_PEAK_EN adds the peak-level status signal.
interface fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    import fifo_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] din;
    logic             write;
    logic             read;
    logic             flush;
    logic [WIDTH-1:0] dout;
    logic             read_stb;
    cond_t            condition;
    logic [AW:0]      level;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
`ifdef FIFO_PEAK_EN
    logic [AW:0]      peak;

    modport master (
        output din, write, read, flush,
        input  dout, read_stb, condition, level, almost_full, almost_empty,
               overflow, underflow, peak
    );

    modport slave (
        input  din, write, read, flush,
        output dout, read_stb, condition, level, almost_full, almost_empty,
               overflow, underflow, peak
    );
`else
    modport master (
        output din, write, read, flush,
        input  dout, read_stb, condition, level, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  din, write, read, flush,
        output dout, read_stb, condition, level, almost_full, almost_empty,
               overflow, underflow
    );
`endif

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read, no reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with exact level, thresholds, flush and sticky error flags.
// Define FIFO_PEAK_EN to track the highest level seen since reset/flush.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 256,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic         clk,
    input  logic         rst,
    fifo_param_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   LVL_AE   = (AW+1)'(AE_THRESH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      level;
    logic [AW:0]      level_next;
    logic             is_full;
    logic             is_empty;
    logic             wr_ok;
    logic             rd_ok;
    logic             has_read;
    logic             read_stb_q;
    logic             overflow_q;
    logic             underflow_q;
    logic [WIDTH-1:0] ram_q;

    assign is_full  = (level == LVL_FULL);
    assign is_empty = (level == '0);
    assign wr_ok    = bus.write & ~is_full;
    assign rd_ok    = bus.read & ~is_empty;

    always_comb begin
        level_next = level;
        case ({wr_ok, rd_ok})
            2'b10:   level_next = level + LVL_ONE;
            2'b01:   level_next = level - LVL_ONE;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            level       <= '0;
            read_stb_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            has_read    <= 1'b0;
        end else if (bus.flush) begin
            // dout is deliberately left alone, so has_read survives a flush
            head        <= '0;
            tail        <= '0;
            level       <= '0;
            read_stb_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok)
                head <= head + PTR_ONE;
            if (rd_ok) begin
                tail     <= tail + PTR_ONE;
                has_read <= 1'b1;
            end
            level      <= level_next;
            read_stb_q <= rd_ok;
            if (bus.write && is_full)
                overflow_q <= 1'b1;
            if (bus.read && is_empty)
                underflow_q <= 1'b1;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok & ~bus.flush),
        .wr_addr (head),
        .wr_data (bus.din),
        .rd_en   (rd_ok & ~bus.flush),
        .rd_addr (tail),
        .rd_data (ram_q)
    );

    // The RAM read register has no reset; mask it until the first accepted read.
    assign bus.dout         = has_read ? ram_q : '0;
    assign bus.read_stb     = read_stb_q;
    assign bus.condition    = cond_decode(is_empty, is_full);
    assign bus.level        = level;
    assign bus.almost_full  = (level >= LVL_AF);
    assign bus.almost_empty = (level <= LVL_AE);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

`ifdef FIFO_PEAK_EN
    logic [AW:0] peak_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            peak_q <= '0;
        else if (bus.flush)
            peak_q <= '0;
        else if (level_next > peak_q)
            peak_q <= level_next;
    end

    assign bus.peak = peak_q;
`endif

endmodule
